// File: rtl/mult_result_collector.sv
// Capture stage for the 4x4 shift-add multiplier: samples each finished product into a small FIFO.
// Define MULT_COLLECT_PARITY_EN to store an even-parity bit per entry and expose it on m_parity.
module mult_result_collector #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cnt_done_n,
    input  logic [3:0]               acv_qn,
    input  logic [3:0]               mrv_qn,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [7:0]               m_data,
`ifdef MULT_COLLECT_PARITY_EN
    output logic                     m_parity,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [1:0]               fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
`ifdef MULT_COLLECT_PARITY_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    product;
    logic [EW-1:0] entry;
    logic          pop;
    logic          push;
    logic          drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort in RUN takes priority over a coincident terminal-count flag.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ARMED;
            ARMED:   if (!start && cnt_done_n) state_next = RUN;
            RUN: begin
                if (start)            state_next = ARMED;
                else if (!cnt_done_n) state_next = CAPTURE;
            end
            CAPTURE: state_next = start ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
        end
    end

    assign fsm_state = state;

    // Register outputs are Q-bar nets, so the true product is the inverse.
    assign product = ~{acv_qn, mrv_qn};
`ifdef MULT_COLLECT_PARITY_EN
    assign entry = {^product, product};
`else
    assign entry = product;
`endif

    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;
    assign push    = (state == CAPTURE) && ((level < FULL_LVL) || pop);
    assign drop    = (state == CAPTURE) && !push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign m_data = mem[rd_ptr][7:0];
`ifdef MULT_COLLECT_PARITY_EN
    assign m_parity = mem[rd_ptr][8];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_result_collector.sv
// Bench for mult_result_collector: vector table, corner-case sequences and randomized traffic
// checked against a queue model. Covers the parity build when MULT_COLLECT_PARITY_EN is defined.
module tb_mult_result_collector;

    localparam int DEPTH = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cnt_done_n;
    logic [3:0] acv_qn;
    logic [3:0] mrv_qn;
    logic       man_ready;
    logic       rnd_ready;
    logic       rand_mode;
    logic       m_ready;

    logic       m_valid;
    logic [7:0] m_data;
    logic [2:0] level;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [1:0] fsm_state;

    logic       s_valid;
    logic [7:0] s_data;
    logic [2:0] s_level;
    logic       s_busy;
    logic [1:0] s_drop;
    logic [1:0] s_state;
`ifdef MULT_COLLECT_PARITY_EN
    logic       m_parity;
    logic       s_parity;
`endif

    assign m_ready = rand_mode ? rnd_ready : man_ready;

    always #5 clk = ~clk;

    mult_result_collector #(.DEPTH(DEPTH), .DROP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cnt_done_n(cnt_done_n),
        .acv_qn(acv_qn), .mrv_qn(mrv_qn), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data),
`ifdef MULT_COLLECT_PARITY_EN
        .m_parity(m_parity),
`endif
        .level(level), .busy(busy), .drop_cnt(drop_cnt), .fsm_state(fsm_state)
    );

    mult_result_collector #(.DEPTH(DEPTH), .DROP_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .cnt_done_n(cnt_done_n),
        .acv_qn(acv_qn), .mrv_qn(mrv_qn), .m_valid(s_valid), .m_ready(m_ready),
        .m_data(s_data),
`ifdef MULT_COLLECT_PARITY_EN
        .m_parity(s_parity),
`endif
        .level(s_level), .busy(s_busy), .drop_cnt(s_drop), .fsm_state(s_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int minv(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: results queue plus drop tally, advanced once per clock.
    logic [7:0] exp_q[$];
    int         mdl_drops = 0;
    bit         cap_now = 1'b0;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        bit pop;
        bit acc;
        if (!rst_n) begin
            exp_q.delete();
            mdl_drops = 0;
        end else begin
            pop = m_ready && (exp_q.size() != 0);
            acc = (exp_q.size() < DEPTH) || pop;
            if (pop) void'(exp_q.pop_front());
            if (cap_now) begin
                if (acc) exp_q.push_back(~{acv_qn, mrv_qn});
                else     mdl_drops++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_level", level, exp_q.size());
            check("mdl_valid", m_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("mdl_data", m_data, exp_q[0]);
            check("mdl_drop", drop_cnt, minv(mdl_drops, 255));
            check("mdl_drop_sat", s_drop, minv(mdl_drops, 3));
        end
    end

    always @(negedge clk) rnd_ready = 1'($urandom_range(0, 1));

    typedef struct {
        logic [3:0] a;
        logic [3:0] m;
        int         run;
        logic [7:0] prod;
    } vec_t;
    vec_t tbl[6];

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full multiply. Operand nets carry junk except in the CAPTURE cycle.
    // rdy_cap >= 0 forces m_ready to that value during CAPTURE only.
    task automatic do_mult(input logic [3:0] a, input logic [3:0] m, input int run, input int rdy_cap);
        logic saved;
        @(negedge clk);
        start = 1'b1; cnt_done_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (run) @(negedge clk);
        @(negedge clk);
        cnt_done_n = 1'b0; acv_qn = ~a; mrv_qn = ~m;
        @(negedge clk);
        cnt_done_n = 1'b1; acv_qn = a; mrv_qn = m; cap_now = 1'b1;
        saved = man_ready;
        if (rdy_cap >= 0) man_ready = rdy_cap[0];
        @(negedge clk);
        cap_now = 1'b0; acv_qn = ~a; mrv_qn = ~m;
        man_ready = saved;
    endtask

    initial begin
        tbl[0] = '{4'hA, 4'h3, 0, 8'h5C};
        tbl[1] = '{4'hF, 4'hF, 1, 8'h00};
        tbl[2] = '{4'h0, 4'h0, 2, 8'hFF};
        tbl[3] = '{4'h5, 4'hA, 0, 8'hA5};
        tbl[4] = '{4'hC, 4'h1, 3, 8'h3E};
        tbl[5] = '{4'h2, 4'hD, 1, 8'hD2};

        rst_n = 1'b0; start = 1'b0; cnt_done_n = 1'b1;
        acv_qn = 4'hF; mrv_qn = 4'hF; man_ready = 1'b0; rand_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 8'h00);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_state", fsm_state, ST_IDLE);
        chk_en = 1'b1;

        // Table: single multiplies with the consumer always ready.
        man_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_mult(tbl[i].a, tbl[i].m, tbl[i].run, -1);
            check("tbl_valid", m_valid, 1);
            check("tbl_data", m_data, tbl[i].prod);
            @(negedge clk);
            check("tbl_drain", level, 0);
        end

        // Backpressure: six results into four slots.
        apply_reset();
        man_ready = 1'b0;
        for (int i = 0; i < 6; i++) do_mult(tbl[i].a, tbl[i].m, 0, -1);
        check("bp_level", level, 4);
        check("bp_drop", drop_cnt, 2);
        check("bp_drop_sat", s_drop, 2);
        repeat (2) @(negedge clk);
        check("bp_hold", m_data, tbl[0].prod);
        man_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_order", m_data, tbl[i].prod);
            @(negedge clk);
        end
        check("bp_empty", m_valid, 0);

        // Full FIFO with a pop in the CAPTURE cycle.
        apply_reset();
        man_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_mult(tbl[i].a, tbl[i].m, 0, -1);
        do_mult(tbl[4].a, tbl[4].m, 1, 1);
        check("fp_level", level, 4);
        check("fp_drop", drop_cnt, 0);
        man_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("fp_order", m_data, tbl[i].prod);
            @(negedge clk);
        end
        check("fp_empty", level, 0);

        // Abort in RUN, ARMED waiting on terminal count, start during CAPTURE.
        apply_reset();
        man_ready = 1'b0;
        do_mult(tbl[0].a, tbl[0].m, 0, -1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        check("ab_state", fsm_state, ST_ARMED);
        check("ab_busy", busy, 1);
        check("ab_level", level, 1);
        check("ab_drop", drop_cnt, 0);
        start = 1'b0; cnt_done_n = 1'b0;
        @(negedge clk);
        check("ab_armed_wait", fsm_state, ST_ARMED);
        cnt_done_n = 1'b1;
        @(negedge clk);
        cnt_done_n = 1'b0; acv_qn = 4'h0; mrv_qn = 4'hF;
        @(negedge clk);
        cnt_done_n = 1'b1; acv_qn = 4'h3; mrv_qn = 4'h6; cap_now = 1'b1; start = 1'b1;
        @(negedge clk);
        cap_now = 1'b0; start = 1'b0;
        check("cs_state", fsm_state, ST_ARMED);
        check("cs_level", level, 2);
        @(negedge clk);
        cnt_done_n = 1'b0;
        @(negedge clk);
        cnt_done_n = 1'b1; acv_qn = 4'h9; mrv_qn = 4'h9; cap_now = 1'b1;
        @(negedge clk);
        cap_now = 1'b0;
        check("cs_level2", level, 3);
        man_ready = 1'b1;
        check("cs_head", m_data, 8'h5C);
        @(negedge clk);
        check("cs_second", m_data, 8'hC9);
        @(negedge clk);
        check("cs_third", m_data, 8'h66);

        // Drop counter saturation on the 2-bit instance.
        apply_reset();
        man_ready = 1'b0;
        for (int i = 0; i < 9; i++) do_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, -1);
        check("sat_drop", drop_cnt, 5);
        check("sat_drop_sat", s_drop, 3);
        check("sat_level", level, 4);

        // Reset mid-RUN with two queued results.
        apply_reset();
        do_mult(tbl[3].a, tbl[3].m, 0, -1);
        do_mult(tbl[4].a, tbl[4].m, 0, -1);
        check("mr_level_pre", level, 2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("mr_valid", m_valid, 0);
        check("mr_data", m_data, 8'h00);
        check("mr_level", level, 0);
        check("mr_busy", busy, 0);
        check("mr_drop", drop_cnt, 0);
        check("mr_state", fsm_state, ST_IDLE);

`ifdef MULT_COLLECT_PARITY_EN
        apply_reset();
        man_ready = 1'b0;
        do_mult(4'hA, 4'h3, 0, -1);
        do_mult(4'hA, 4'h2, 0, -1);
        check("par_data0", m_data, 8'h5C);
        check("par_bit0", m_parity, 0);
        check("par_bit0_sat", s_parity, 0);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        check("par_data1", m_data, 8'h5D);
        check("par_bit1", m_parity, 1);
        check("par_bit1_sat", s_parity, 1);
`endif

        // Randomized traffic with a random consumer.
        apply_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3), -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_mode = 1'b0;
        man_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rnd_drained", level, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_result_collector.md
# mult_result_collector

Downstream capture stage for the 4x4 shift-add multiplier datapath. It watches the multiplier's cycle counter terminal flag, samples the 8-bit product from the accumulator and multiplier registers when a multiply completes, and queues results in a small FIFO. Consumers read the FIFO over a valid/ready stream. Results that arrive while the FIFO is full are dropped and counted, so the multiplier never stalls.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `DROP_W`, default 8: width of the saturating drop counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: same signal that drives the multiplier START input; level-sampled.
- `cnt_done_n` in 1: multiplier CNTVCON2 flag; low while the counter is at terminal value 7.
- `acv_qn` in 4: accumulator register Q-bar nets ACVQN3..0, i.e. inverted polarity.
- `mrv_qn` in 4: multiplier register Q-bar nets MRVQN3..0, i.e. inverted polarity.
- `m_valid` out 1: FIFO head is valid.
- `m_ready` in 1: consumer accepts the head.
- `m_data` out 8: product {~acv_qn, ~mrv_qn} at capture.
- `level` out clog2(DEPTH)+1: current FIFO occupancy.
- `busy` out 1: a multiply is in flight (FSM not in IDLE).
- `drop_cnt` out DROP_W: number of results lost to a full FIFO; saturates at all-ones.

## Operation
FSM states and transitions:
- IDLE: `start`=1 → ARMED.
- ARMED: waits for the multiplier to leave terminal count.
  - `start`=0 and `cnt_done_n`=1 → RUN.
  - `start` still 1 → stay in ARMED.
- RUN: waits for the first sampled `cnt_done_n`=0, then → CAPTURE.
- CAPTURE: spends one cycle.
  - Samples {~acv_qn, ~mrv_qn}.
  - Pushes the sample if `level`<DEPTH, or if `level`==DEPTH and a pop occurs this same cycle.
  - Otherwise drops the sample and increments `drop_cnt` (saturating).
  - Next state is IDLE.
- `start`=1 while in RUN: aborts the current multiply. Return to ARMED, no push, no drop count.
- `start`=1 in the CAPTURE cycle: the capture still completes. Next state is ARMED instead of IDLE.

FIFO:
- Circular buffer with write and read pointers of clog2(DEPTH) bits; both wrap modulo DEPTH.
- Pop occurs when `m_valid` && `m_ready`.
- `m_data` always shows the entry at the read pointer. It holds stable while `m_valid`=1 and `m_ready`=0.
- Push and pop in the same cycle: `level` unchanged. This is legal at empty only if the pushed word bypasses nothing; push into an empty FIFO is visible one cycle later.
- `level` never exceeds DEPTH. A pop when `m_valid`=0 is ignored.

Reset values:
- FSM = IDLE.
- `m_valid`=0, `m_data`=8'h00, `level`=0, `busy`=0, `drop_cnt`=0.
- Pointers = 0.
- Reset mid-operation discards every queued and in-flight result.

## Timing
- `cnt_done_n` must be low for at least one sampled cycle; the multiplier holds it low for one count.
- Capture latency: the product is sampled on the clock edge ending the CAPTURE cycle, which is one cycle after `cnt_done_n` is first seen low in RUN.
- Push-to-visibility: `m_valid` rises one cycle after the push edge.
- Full FIFO with `m_ready`=1 in the CAPTURE cycle: the pop and the push both happen. `level` stays DEPTH and `drop_cnt` does not change.
- No combinational path from `m_ready` to `m_valid` or `m_data`.
- `busy` is registered; it is 1 in ARMED, RUN and CAPTURE.

## Configuration
- `MULT_COLLECT_PARITY_EN` defined:
  - FIFO entries are 9 bits; bit 8 holds the even parity ^product computed at capture.
  - Adds an output port `m_parity`, 1 bit, reset value 0, aligned with `m_data`.
- Not defined:
  - 8-bit entries and no `m_parity` port.
  - All other behaviour is identical.

## Test plan
- Single multiply, `m_ready`=1:
  - Stimulus: `start` pulse, then RUN, then `cnt_done_n` low one cycle with `acv_qn`=4'hA, `mrv_qn`=4'h3.
  - Required: `m_data`=8'h5C with `m_valid` for one cycle, two cycles after the `cnt_done_n` sample; `level` back to 0.
- Backpressure with DEPTH=4, `m_ready`=0:
  - Stimulus: six completed multiplies.
  - Required: `level`=4, `drop_cnt`=2. Releasing `m_ready` yields the first four products in order.
- Full FIFO with simultaneous pop: at `level`=4 with `m_ready`=1 during CAPTURE → `level` stays 4, `drop_cnt` unchanged, and the new product is last in the read order.
- Abort: `start` reasserted in RUN before `cnt_done_n` goes low → no push, `drop_cnt` unchanged, FSM in ARMED.
- Saturation and reset:
  - Stimulus: DROP_W=2 with 5 drops.
  - Required: `drop_cnt`=3.
  - Stimulus: `rst_n`=0 for one edge mid-RUN with 2 queued entries.
  - Required: all outputs at their reset values the next cycle.
- Parity build: with `MULT_COLLECT_PARITY_EN`, product 8'h5C → `m_parity`=0; product 8'h5D → `m_parity`=1.
